seg7_rx_checker: RTL and testbench

// Receive end of the seven-segment digit interface. Samples an external 7-bit

---
 rtl/seg7_rx_checker.sv | 166 ++++++++++++++++
 tb/tb_seg7_rx_checker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_rx_checker.sv
// seg7_rx_checker
//    Receive side of a seven-segment digit bus. The asynchronous segment bus
//    is synchronized and debounced. Each newly stable pattern is decoded back
//    to a digit 0-9 and checked against the 0..9 wrap sequence. The number of
//    clock edges between consecutive digits is measured.
//
// Ports
//    clk           clock
//    rst_n         asynchronous active-low reset
//    ena           1 = run; 0 = freeze everything except the input synchronizer
//    seg_in[6:0]   segment bus, bit0 = a ... bit6 = g, active-high, async to clk
//    clr_err       synchronous clear of both sticky error flags
//    digit_out     last accepted decoded digit
//    digit_valid   one-cycle pulse per newly accepted valid digit
//    interval_out  clk edges between the previous and current digit_valid pulses
//    seq_err       sticky: accepted digit was not previous+1 (mod 10)
//    pat_err       sticky: accepted pattern is not a digit pattern
//
// state      | meaning
// -----------+----------------------------------------------------------
// WAIT_FIRST | no valid digit seen since reset; next valid digit is not
//            | sequence-checked and reports interval 0
// LOCKED     | a valid digit has been accepted; every further valid digit
//            | is checked against previous+1 (mod 10)
module seg7_rx_checker #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [6:0]       seg_in,
   input  logic             clr_err,
   output logic [3:0]       digit_out,
   output logic             digit_valid,
   output logic [CNT_W-1:0] interval_out,
   output logic             seq_err,
   output logic             pat_err
);

   localparam int              SC_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);

   typedef enum logic {
      WAIT_FIRST = 1'b0,
      LOCKED     = 1'b1
   } state_t;

   state_t           state;
   logic [6:0]       s1;
   logic [6:0]       s2;
   logic [6:0]       cand;
   logic [6:0]       last_pat;
   logic [SC_W-1:0]  cnt;
   logic [CNT_W-1:0] cnt_iv;

   logic [6:0]       cand_nxt;
   logic [SC_W-1:0]  cnt_nxt;
   logic             accept;
   logic [3:0]       dec_digit;
   logic             dec_ok;
   logic [3:0]       exp_digit;
   logic             digit_acc;
   logic             seq_set;
   logic             pat_set;

   // The synchronizer runs regardless of ena so that on resume the filter
   // sees the current bus, not a stale one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 7'h00;
         s2 <= 7'h00;
      end else begin
         s1 <= seg_in;
         s2 <= s1;
      end
   end

   always_comb begin
      cand_nxt = cand;
      cnt_nxt  = cnt;
      if (s2 != cand) begin
         cand_nxt = s2;
         cnt_nxt  = SC_W'(1);
      end else if (cnt != SC_MAX) begin
         cnt_nxt = cnt + SC_W'(1);
      end
   end

   // Comparing against last_pat (which follows every accept, valid or not)
   // keeps a saturated count from re-firing on the same pattern.
   assign accept = (cnt_nxt == SC_MAX) && (cand_nxt != last_pat);

   always_comb begin
      dec_ok    = 1'b1;
      dec_digit = 4'd0;
      case (cand_nxt)
         7'h3F: dec_digit = 4'd0;
         7'h06: dec_digit = 4'd1;
         7'h5B: dec_digit = 4'd2;
         7'h4F: dec_digit = 4'd3;
         7'h66: dec_digit = 4'd4;
         7'h6D: dec_digit = 4'd5;
         7'h7C: dec_digit = 4'd6;
         7'h07: dec_digit = 4'd7;
         7'h7F: dec_digit = 4'd8;
         7'h67: dec_digit = 4'd9;
         default: dec_ok = 1'b0;
      endcase
   end

   assign exp_digit = (digit_out == 4'd9) ? 4'd0 : digit_out + 4'd1;
   assign digit_acc = accept && dec_ok;
   assign seq_set   = digit_acc && (state == LOCKED) && (dec_digit != exp_digit);
   assign pat_set   = accept && !dec_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= WAIT_FIRST;
         cand         <= 7'h00;
         cnt          <= '0;
         last_pat     <= 7'h00;
         cnt_iv       <= '0;
         digit_out    <= 4'd0;
         digit_valid  <= 1'b0;
         interval_out <= '0;
         seq_err      <= 1'b0;
         pat_err      <= 1'b0;
      end else begin
         digit_valid <= 1'b0;
         if (ena) begin
            cand <= cand_nxt;
            cnt  <= cnt_nxt;
            if (accept) begin
               last_pat <= cand_nxt;
            end

            if (digit_acc) begin
               cnt_iv <= CNT_W'(1);
            end else if (!(&cnt_iv)) begin
               cnt_iv <= cnt_iv + CNT_W'(1);
            end

            // A set on the same edge as a clear wins.
            seq_err <= seq_set | (seq_err & ~clr_err);
            pat_err <= pat_set | (pat_err & ~clr_err);

            if (digit_acc) begin
               digit_out   <= dec_digit;
               digit_valid <= 1'b1;
               case (state)
                  WAIT_FIRST: begin
                     state        <= LOCKED;
                     interval_out <= '0;
                  end
                  LOCKED: begin
                     interval_out <= cnt_iv;
                  end
                  default: state <= WAIT_FIRST;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_rx_checker.sv
// tb_seg7_rx_checker
//    Testbench for seg7_rx_checker. Two instances share all inputs: the
//    default one (CNT_W=24) and a narrow one (CNT_W=4) for interval saturation.
module tb_seg7_rx_checker;

   localparam int S = 4;
   localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [6:0]  seg_in;
   logic        clr_err;

   logic [3:0]  digit_out;
   logic        digit_valid;
   logic [23:0] interval_out;
   logic        seq_err;
   logic        pat_err;

   logic [3:0]  d4_digit_out;
   logic        d4_digit_valid;
   logic [3:0]  d4_interval_out;
   logic        d4_seq_err;
   logic        d4_pat_err;

   always #5 clk = ~clk;

   seg7_rx_checker #(.STABLE_CYCLES(S), .CNT_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in), .clr_err(clr_err),
      .digit_out(digit_out), .digit_valid(digit_valid), .interval_out(interval_out),
      .seq_err(seq_err), .pat_err(pat_err)
   );

   seg7_rx_checker #(.STABLE_CYCLES(S), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in), .clr_err(clr_err),
      .digit_out(d4_digit_out), .digit_valid(d4_digit_valid), .interval_out(d4_interval_out),
      .seq_err(d4_seq_err), .pat_err(d4_pat_err)
   );

   int tests = 0;
   int fails = 0;
   int pulses = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a pattern is accepted once the synchronized stream has
   // shown it for exactly S consecutive samples and it differs from the last
   // accepted pattern. hist[k+1] holds seg_in as sampled on post-reset edge k;
   // indices 0 and 1 stand for the reset value of the synchronizer.
   bit          model_on = 0;
   int          k;
   logic [6:0]  hist [8192];
   logic [6:0]  m_last;
   bit          m_locked;
   int          m_digit;
   bit          m_dv;
   longint      m_iv;
   longint      m_iv4;
   int          m_kprev;
   bit          m_seq;
   bit          m_pat;

   task automatic model_reset();
      k = 0;
      hist[0] = 7'h00;
      hist[1] = 7'h00;
      m_last = 7'h00;
      m_locked = 0;
      m_digit = 0;
      m_dv = 0;
      m_iv = 0;
      m_iv4 = 0;
      m_kprev = 0;
      m_seq = 0;
      m_pat = 0;
   endtask

   task automatic model_edge();
      logic [6:0] p;
      int run;
      int d;
      bit sset;
      bit pset;
      k++;
      hist[k+1] = seg_in;
      p = hist[k-1];
      run = 0;
      sset = 0;
      pset = 0;
      m_dv = 0;
      for (int j = k - 1; j >= 0; j--) begin
         if (hist[j] != p || run > S) break;
         run++;
      end
      if (run == S && p != m_last) begin
         m_last = p;
         d = -1;
         for (int i = 0; i < 10; i++) if (PAT[i] == p) d = i;
         if (d < 0) begin
            pset = 1;
         end else begin
            if (m_locked) begin
               if (d != (m_digit + 1) % 10) sset = 1;
               m_iv  = (k - m_kprev > 24'hFFFFFF) ? 24'hFFFFFF : k - m_kprev;
               m_iv4 = (k - m_kprev > 15) ? 15 : k - m_kprev;
            end else begin
               m_iv  = 0;
               m_iv4 = 0;
            end
            m_locked = 1;
            m_digit = d;
            m_dv = 1;
            m_kprev = k;
         end
      end
      m_seq = sset ? 1'b1 : (clr_err ? 1'b0 : m_seq);
      m_pat = pset ? 1'b1 : (clr_err ? 1'b0 : m_pat);
   endtask

   task automatic model_check();
      logic [63:0] act;
      logic [63:0] exp;
      act = {digit_valid, digit_out, seq_err, pat_err, d4_interval_out, interval_out};
      exp = {m_dv, 4'(m_digit), m_seq, m_pat, 4'(m_iv4), 24'(m_iv)};
      check($sformatf("rand_cycle_k%0d", k), act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      if (model_on) model_edge();
      @(negedge clk);
      if (digit_valid) pulses++;
      if (model_on) model_check();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ena = 1'b1;
      clr_err = 1'b0;
      seg_in = 7'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Ticks until digit_valid or the budget runs out; n is the edge count or -1.
   task automatic wait_pulse(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (digit_valid) begin
            n = i;
            break;
         end
      end
   endtask

   typedef struct {
      logic [6:0] seg;
      int         hold;
      logic       clr;
      int         pulses;
      int         digit;
      logic       seq;
      logic       pat;
      int         iv;
   } vec_t;

   vec_t vt [18];

   initial begin
      int first;
      int n;
      int cur_d;
      int r;
      int hold;
      logic [6:0] p;

      vt[0]  = '{7'h06, 100, 1'b0, 1, 1, 1'b0, 1'b0, 100};
      vt[1]  = '{7'h5B, 100, 1'b0, 1, 2, 1'b0, 1'b0, 100};
      vt[2]  = '{7'h4F, 100, 1'b0, 1, 3, 1'b0, 1'b0, 100};
      vt[3]  = '{7'h66, 100, 1'b0, 1, 4, 1'b0, 1'b0, 100};
      vt[4]  = '{7'h6D, 100, 1'b0, 1, 5, 1'b0, 1'b0, 100};
      vt[5]  = '{7'h7C, 100, 1'b0, 1, 6, 1'b0, 1'b0, 100};
      vt[6]  = '{7'h07, 100, 1'b0, 1, 7, 1'b0, 1'b0, 100};
      vt[7]  = '{7'h7F, 100, 1'b0, 1, 8, 1'b0, 1'b0, 100};
      vt[8]  = '{7'h67, 100, 1'b0, 1, 9, 1'b0, 1'b0, 100};
      vt[9]  = '{7'h3F, 100, 1'b0, 1, 0, 1'b0, 1'b0, 100};
      vt[10] = '{7'h06,   3, 1'b0, 0, 0, 1'b0, 1'b0, 100};
      vt[11] = '{7'h3F,  20, 1'b0, 0, 0, 1'b0, 1'b0, 100};
      vt[12] = '{7'h4F,  20, 1'b0, 1, 3, 1'b1, 1'b0, 123};
      vt[13] = '{7'h4F,   5, 1'b1, 0, 3, 1'b0, 1'b0, 123};
      vt[14] = '{7'h66,  20, 1'b0, 1, 4, 1'b0, 1'b0,  25};
      vt[15] = '{7'h00,  10, 1'b0, 0, 4, 1'b0, 1'b1,  25};
      vt[16] = '{7'h12,  10, 1'b0, 0, 4, 1'b0, 1'b1,  25};
      vt[17] = '{7'h6D,  20, 1'b0, 1, 5, 1'b0, 1'b1,  40};

      // Reset values, checked while reset is held.
      rst_n = 1'b0;
      ena = 1'b1;
      clr_err = 1'b0;
      seg_in = 7'h00;
      #1;
      check("reset_outputs", {digit_valid, digit_out, interval_out, seq_err, pat_err}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // First digit latency: 3F held from reset release for 100 edges.
      seg_in = 7'h3F;
      first = -1;
      for (int e = 1; e <= 100; e++) begin
         tick();
         if (digit_valid && first < 0) first = e;
      end
      check("first_latency", first, 6);
      check("first_digit", digit_out, 0);
      check("first_interval", interval_out, 0);
      check("first_errs", {seq_err, pat_err}, 0);

      // Table-driven sequence.
      for (int v = 0; v < 18; v++) begin
         seg_in = vt[v].seg;
         clr_err = vt[v].clr;
         pulses = 0;
         for (int c = 0; c < vt[v].hold; c++) tick();
         check($sformatf("vec%0d_pulses", v), pulses, vt[v].pulses);
         check($sformatf("vec%0d_digit", v), digit_out, vt[v].digit);
         check($sformatf("vec%0d_seq_err", v), seq_err, vt[v].seq);
         check($sformatf("vec%0d_pat_err", v), pat_err, vt[v].pat);
         check($sformatf("vec%0d_interval", v), interval_out, vt[v].iv);
      end
      clr_err = 1'b0;

      // Sequence error while clr_err is held: the set wins on its edge.
      seg_in = 7'h3F;
      clr_err = 1'b1;
      wait_pulse(20, n);
      check("setwins_latency", n, 6);
      check("setwins_seq_err", seq_err, 1);
      tick();
      check("setwins_cleared", {seq_err, pat_err}, 0);
      clr_err = 1'b0;

      // Interval saturation in the narrow instance.
      seg_in = 7'h06;
      for (int c = 0; c < 40; c++) tick();
      seg_in = 7'h5B;
      for (int c = 0; c < 20; c++) tick();
      check("sat_interval_w24", interval_out, 40);
      check("sat_interval_w4", d4_interval_out, 15);
      check("sat_digit", digit_out, 2);

      // ena=0 freezes; synchronizer keeps sampling, so resume takes S edges.
      ena = 1'b0;
      seg_in = 7'h4F;
      pulses = 0;
      for (int c = 0; c < 20; c++) tick();
      check("ena_off_pulses", pulses, 0);
      check("ena_off_digit", digit_out, 2);
      ena = 1'b1;
      wait_pulse(20, n);
      check("ena_resume_latency", n, S);
      check("ena_resume_digit", digit_out, 3);

      // Asynchronous reset in the middle of filtering.
      seg_in = 7'h66;
      tick();
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", {digit_valid, digit_out, interval_out, seq_err, pat_err}, 64'd0);
      check("midreset_w4_outputs", {d4_digit_valid, d4_digit_out, d4_interval_out}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_pulse(20, n);
      check("postreset_latency", n, 6);
      check("postreset_digit", digit_out, 4);
      check("postreset_interval", interval_out, 0);
      check("postreset_seq_err", seq_err, 0);

      // Randomized traffic against the reference model.
      do_reset();
      model_on = 1;
      cur_d = 0;
      while (k < 2000) begin
         r = $urandom_range(0, 9);
         hold = $urandom_range(4, 25);
         if (r < 6) begin
            cur_d = (cur_d + 1) % 10;
            p = PAT[cur_d];
         end else if (r < 8) begin
            cur_d = $urandom_range(0, 9);
            p = PAT[cur_d];
         end else if (r == 8) begin
            p = 7'($urandom);
         end else begin
            p = 7'($urandom);
            hold = $urandom_range(1, 3);
         end
         seg_in = p;
         for (int c = 0; c < hold; c++) begin
            clr_err = ($urandom_range(0, 15) == 0);
            tick();
         end
      end
      model_on = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
